// File: rtl/hamming_serializer.sv
// -----------------------------------------------------------------------------
// hamming_serializer
//
// Buffers 4-bit data words in a small circular FIFO, encodes each into a
// Hamming(7,4) codeword (even parity) and shifts it out one bit per clock.
// Every word is framed by exactly 7 contiguous strobe-high cycles followed by
// GAP_CYCLES strobe-low cycles, in which the downstream corrector decodes.
// Transmission order is codeword position 1 (p1) first, position 7 (d3) last.
//
// Optional feature macro: HAMM_ERR_INJECT_EN
//   Defined   : adds input err_pos[2:0], sampled when a word is popped.
//               A value of 1..7 inverts that codeword position on the wire,
//               0 leaves the word intact.
//   Undefined : no err_pos port, codewords always go out uncorrupted.
//
// Parameters:
//   FIFO_DEPTH  input buffer depth in words (power of two, >= 2)
//   GAP_CYCLES  strobe-low cycles forced after each word (>= 1)
//
// Ports:
//   clk         rising-edge system clock
//   rst         asynchronous active-high reset
//   d_in        data word, d_in[0] is d0
//   in_valid    d_in is presented for writing
//   in_ready    FIFO not full; write happens on in_valid & in_ready
//   err_pos     (HAMM_ERR_INJECT_EN only) codeword position to invert
//   d_hamm      registered serial codeword bit
//   strobe      registered, high while d_hamm carries a codeword bit
//   busy        FSM not idle or FIFO non-empty
//   fifo_count  current FIFO occupancy
// -----------------------------------------------------------------------------
module hamming_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    d_in,
    input  logic                          in_valid,
    output logic                          in_ready,
`ifdef HAMM_ERR_INJECT_EN
    input  logic [2:0]                    err_pos,
`endif
    output logic                          d_hamm,
    output logic                          strobe,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    // ------------------------------------------------------------------ FIFO
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full, empty, push, pop;

    state_t        state_q;
    logic [5:0]    sr_q;        // remaining codeword bits, next to send in [0]
    logic [2:0]    idx_q;       // codeword position currently on the wire
    logic [GW-1:0] gap_q;
    logic          d_hamm_q;
    logic          strobe_q;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    // Ready comes from pre-edge occupancy only: a pop in the same cycle
    // does not open a slot for a push while full.
    assign push  = in_valid & ~full;
    // Pop in IDLE, or on the last gap cycle so back-to-back words keep the
    // 7 + GAP_CYCLES cadence.
    assign pop   = ~empty & ((state_q == S_IDLE) |
                             ((state_q == S_GAP) & (gap_q == GW'(1))));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= d_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // --------------------------------------------------------------- encoder
    logic [3:0] head;
    logic [6:0] cw;         // cw[k] is codeword position k+1
    logic [6:0] err_mask;
    logic [6:0] tx_word;

    assign head  = mem_q[rd_ptr_q];
    assign cw[0] = head[0] ^ head[1] ^ head[3];   // p1
    assign cw[1] = head[0] ^ head[2] ^ head[3];   // p2
    assign cw[2] = head[0];                       // d0
    assign cw[3] = head[1] ^ head[2] ^ head[3];   // p4
    assign cw[4] = head[1];                       // d1
    assign cw[5] = head[2];                       // d2
    assign cw[6] = head[3];                       // d3

`ifdef HAMM_ERR_INJECT_EN
    // The corruption is folded into the word at pop time, so err_pos is
    // effectively held with the word for the whole burst.
    always_comb begin
        err_mask = '0;
        if (err_pos != 3'd0) err_mask = 7'(1) << (err_pos - 3'd1);
    end
`else
    assign err_mask = '0;
`endif

    assign tx_word = cw ^ err_mask;

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sr_q     <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            d_hamm_q <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        d_hamm_q <= tx_word[0];
                        sr_q     <= tx_word[6:1];
                        idx_q    <= 3'd1;
                        strobe_q <= 1'b1;
                        state_q  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (idx_q == 3'd7) begin
                        d_hamm_q <= 1'b0;
                        strobe_q <= 1'b0;
                        gap_q    <= GAP_LOAD;
                        state_q  <= S_GAP;
                    end else begin
                        d_hamm_q <= sr_q[0];
                        sr_q     <= {1'b0, sr_q[5:1]};
                        idx_q    <= idx_q + 3'd1;
                    end
                end
                S_GAP: begin
                    gap_q <= gap_q - GW'(1);
                    if (gap_q == GW'(1)) begin
                        // Counter reaches zero: act as IDLE in this cycle.
                        if (pop) begin
                            d_hamm_q <= tx_word[0];
                            sr_q     <= tx_word[6:1];
                            idx_q    <= 3'd1;
                            strobe_q <= 1'b1;
                            state_q  <= S_SEND;
                        end else begin
                            state_q  <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = ~full;
    assign d_hamm     = d_hamm_q;
    assign strobe     = strobe_q;
    assign busy       = (state_q != S_IDLE) | ~empty;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_hamming_serializer.sv
// -----------------------------------------------------------------------------
// tb_hamming_serializer
//
// Directed self-checking bench for hamming_serializer. Instance dut uses the
// default parameters; dut3 uses GAP_CYCLES=3 for the gap-length scenario.
// Expected codewords are hand-computed and written MSB = position 1.
// -----------------------------------------------------------------------------
module tb_hamming_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d_in, d_in3;
    logic       in_valid, in_valid3;
    logic       in_ready, in_ready3;
    logic       d_hamm, d_hamm3;
    logic       strobe, strobe3;
    logic       busy, busy3;
    logic [2:0] fifo_count, fifo_count3;
`ifdef HAMM_ERR_INJECT_EN
    logic [2:0] err_pos, err_pos3;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    hamming_serializer #(.FIFO_DEPTH(4), .GAP_CYCLES(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
`ifdef HAMM_ERR_INJECT_EN
        .err_pos    (err_pos),
`endif
        .d_hamm     (d_hamm),
        .strobe     (strobe),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    hamming_serializer #(.FIFO_DEPTH(4), .GAP_CYCLES(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in3),
        .in_valid   (in_valid3),
        .in_ready   (in_ready3),
`ifdef HAMM_ERR_INJECT_EN
        .err_pos    (err_pos3),
`endif
        .d_hamm     (d_hamm3),
        .strobe     (strobe3),
        .busy       (busy3),
        .fifo_count (fifo_count3)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; d_in = '0; in_valid = 1'b0; d_in3 = '0; in_valid3 = 1'b0;
`ifdef HAMM_ERR_INJECT_EN
        err_pos = '0; err_pos3 = '0;
`endif
        #1;
        tick; tick;
        tests_run++; if (strobe !== 1'b0)     begin tests_failed++; $display("FAIL reset_strobe: got %b want 0", strobe); end
        tests_run++; if (d_hamm !== 1'b0)     begin tests_failed++; $display("FAIL reset_d_hamm: got %b want 0", d_hamm); end
        tests_run++; if (in_ready !== 1'b1)   begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests_run++; if (busy !== 1'b0)       begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
        rst = 1'b0;
        tick;
    endtask

    // One word into an idle, empty serializer; checks latency, bits and framing.
    task automatic test_encoding(input string name, input logic [3:0] w, input logic [6:0] exp);
        d_in = w; in_valid = 1'b1;
        tick;                       // write edge N
        in_valid = 1'b0;
        tests_run++; if (fifo_count !== 3'd1) begin tests_failed++; $display("FAIL %s_count_after_write: got %0d want 1", name, fifo_count); end
        for (int i = 0; i < 7; i++) begin
            tick;                   // edges N+1 .. N+7
            tests_run++;
            if ({strobe, d_hamm} !== {1'b1, exp[6-i]}) begin
                tests_failed++;
                $display("FAIL %s_pos%0d: got strobe=%b d_hamm=%b want strobe=1 d_hamm=%b", name, i+1, strobe, d_hamm, exp[6-i]);
            end
        end
        tick;                       // edge N+8
        tests_run++; if ({strobe, d_hamm, busy} !== 3'b001) begin tests_failed++; $display("FAIL %s_gap: got strobe=%b d_hamm=%b busy=%b want 0 0 1", name, strobe, d_hamm, busy); end
        tick;                       // edge N+9
        tests_run++; if ({strobe, busy} !== 2'b00) begin tests_failed++; $display("FAIL %s_idle: got strobe=%b busy=%b want 0 0", name, strobe, busy); end
    endtask

    task automatic test_single_word;
        test_encoding("single_1011", 4'b1011, 7'b1010101);
    endtask

    task automatic test_encoding_corners;
        test_encoding("enc_0000", 4'b0000, 7'b0000000);
        test_encoding("enc_1111", 4'b1111, 7'b1111111);
        test_encoding("enc_0001", 4'b0001, 7'b1110000);
    endtask

    task automatic test_backpressure;
        logic [6:0] exp_bp [6];
        logic [6:0] bits;
        int  wi, seen, nbits, gap_run, bad_ready, cyc;
        logic ready_now, saw_full;
        exp_bp[0] = 7'b1110000; exp_bp[1] = 7'b1001100; exp_bp[2] = 7'b0111100;
        exp_bp[3] = 7'b0101010; exp_bp[4] = 7'b1011010; exp_bp[5] = 7'b1100110;
        bits = '0; wi = 0; seen = 0; nbits = 0; gap_run = 0; bad_ready = 0; cyc = 0;
        saw_full = 1'b0;
        while (seen < 6 && cyc < 150) begin
            if (wi < 6) begin in_valid = 1'b1; d_in = 4'(wi + 1); end
            else        in_valid = 1'b0;
            if (in_ready !== (fifo_count != 3'd4)) bad_ready++;
            if (fifo_count == 3'd4) saw_full = 1'b1;
            ready_now = in_ready;
            tick;
            if (wi < 6 && ready_now) wi++;
            if (strobe) begin
                if (nbits == 0 && seen > 0) begin
                    tests_run++;
                    if (gap_run != 1) begin tests_failed++; $display("FAIL bp_gap_before_word%0d: got %0d low cycles want 1", seen+1, gap_run); end
                end
                bits = {bits[5:0], d_hamm};
                nbits++;
                gap_run = 0;
            end else begin
                if (nbits > 0) begin
                    tests_run++;
                    if (nbits != 7 || bits !== exp_bp[seen]) begin
                        tests_failed++;
                        $display("FAIL bp_word%0d: got %0d bits %b want 7 bits %b", seen+1, nbits, bits, exp_bp[seen]);
                    end
                    seen++;
                    nbits = 0;
                end
                gap_run++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        tests_run++; if (seen != 6)     begin tests_failed++; $display("FAIL bp_word_total: got %0d words want 6 (cycle budget)", seen); end
        tests_run++; if (!saw_full)     begin tests_failed++; $display("FAIL bp_reached_full: got max count below 4 want 4"); end
        tests_run++; if (bad_ready != 0) begin tests_failed++; $display("FAIL bp_in_ready_vs_count: got %0d bad cycles want 0", bad_ready); end
        tick; tick;
        tests_run++; if ({strobe, busy, fifo_count} !== 5'b00000) begin tests_failed++; $display("FAIL bp_drain: got strobe=%b busy=%b count=%0d want 0 0 0", strobe, busy, fifo_count); end
    endtask

    task automatic test_reset_mid_word;
        int bad;
        d_in = 4'b0101; in_valid = 1'b1;
        tick;                               // edge 1: write
        d_in = 4'b0011; tick;               // edge 2: pop + write, strobe high #1
        d_in = 4'b0110; tick;               // edge 3: write, high #2
        in_valid = 1'b0;
        tick; tick;                         // edges 4,5: highs #3,#4
        tests_run++; if ({strobe, fifo_count} !== {1'b1, 3'd2}) begin tests_failed++; $display("FAIL rmw_before: got strobe=%b count=%0d want 1 2", strobe, fifo_count); end
        rst = 1'b1;
        #1;
        tests_run++; if ({strobe, d_hamm} !== 2'b00) begin tests_failed++; $display("FAIL rmw_async_strobe: got strobe=%b d_hamm=%b want 0 0", strobe, d_hamm); end
        tests_run++; if ({fifo_count, in_ready} !== {3'd0, 1'b1}) begin tests_failed++; $display("FAIL rmw_async_fifo: got count=%0d in_ready=%b want 0 1", fifo_count, in_ready); end
        tick;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (strobe !== 1'b0 || busy !== 1'b0) bad++;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL rmw_quiet_after_release: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_gap3;
        logic [6:0] exp_g [2];
        logic [6:0] bits;
        int seen, nbits, gap_run, cyc;
        exp_g[0] = 7'b1110000; exp_g[1] = 7'b1001100;
        bits = '0; seen = 0; nbits = 0; gap_run = 0; cyc = 0;
        while (seen < 2 && cyc < 40) begin
            if (cyc == 0)      begin in_valid3 = 1'b1; d_in3 = 4'b0001; end
            else if (cyc == 1) begin in_valid3 = 1'b1; d_in3 = 4'b0010; end
            else               in_valid3 = 1'b0;
            tick;
            if (strobe3) begin
                if (nbits == 0 && seen > 0) begin
                    tests_run++;
                    if (gap_run != 3) begin tests_failed++; $display("FAIL gap3_low_cycles: got %0d want 3", gap_run); end
                end
                bits = {bits[5:0], d_hamm3};
                nbits++;
                gap_run = 0;
            end else begin
                if (nbits > 0) begin
                    tests_run++;
                    if (nbits != 7 || bits !== exp_g[seen]) begin
                        tests_failed++;
                        $display("FAIL gap3_word%0d: got %0d bits %b want 7 bits %b", seen+1, nbits, bits, exp_g[seen]);
                    end
                    seen++;
                    nbits = 0;
                end
                gap_run++;
            end
            cyc++;
        end
        in_valid3 = 1'b0;
        tests_run++; if (seen != 2) begin tests_failed++; $display("FAIL gap3_word_total: got %0d words want 2 (cycle budget)", seen); end
    endtask

`ifdef HAMM_ERR_INJECT_EN
    // Bench-side model of the downstream single-error corrector.
    function automatic logic [3:0] decode(input logic [6:0] r);
        logic [7:1] c;
        int s;
        for (int p = 1; p <= 7; p++) c[p] = r[7-p];
        s = int'(c[1]^c[3]^c[5]^c[7]) + 2*int'(c[2]^c[3]^c[6]^c[7]) + 4*int'(c[4]^c[5]^c[6]^c[7]);
        if (s != 0) c[s] = ~c[s];
        return {c[7], c[6], c[5], c[3]};
    endfunction

    task automatic test_loopback;
        logic [3:0] exp_d [2];
        logic [6:0] bits;
        int seen, nbits, cyc;
        exp_d[0] = 4'b1011; exp_d[1] = 4'b0110;
        bits = '0; seen = 0; nbits = 0; cyc = 0;
        while (seen < 2 && cyc < 40) begin
            if (cyc == 0)      begin in_valid = 1'b1; d_in = 4'b1011; err_pos = 3'd5; end
            else if (cyc == 1) begin in_valid = 1'b0; err_pos = 3'd5; end
            else if (cyc == 2) begin in_valid = 1'b1; d_in = 4'b0110; err_pos = 3'd0; end
            else               begin in_valid = 1'b0; err_pos = 3'd0; end
            tick;
            if (strobe) begin
                bits = {bits[5:0], d_hamm};
                nbits++;
            end else if (nbits > 0) begin
                if (seen == 0) begin
                    tests_run++;
                    if (bits !== 7'b1010001) begin tests_failed++; $display("FAIL loop_raw_word1: got %b want 1010001", bits); end
                end
                tests_run++;
                if (decode(bits) !== exp_d[seen]) begin tests_failed++; $display("FAIL loop_decoded_word%0d: got %b want %b", seen+1, decode(bits), exp_d[seen]); end
                seen++;
                nbits = 0;
            end
            cyc++;
        end
        tests_run++; if (seen != 2) begin tests_failed++; $display("FAIL loop_word_total: got %0d want 2 (cycle budget)", seen); end
        tick; tick;
    endtask
`endif

    initial begin
        test_reset;
        test_single_word;
        test_encoding_corners;
        test_backpressure;
        test_reset_mid_word;
        test_gap3;
`ifdef HAMM_ERR_INJECT_EN
        test_loopback;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
